// File: rtl/sk9822_chain_drv_if.sv
// Host-side bus of the SK9822 chain driver: frame-buffer writes, refresh
// request, and refresh status.
interface sk9822_chain_drv_if #(
  parameter int AW = 1
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [28:0]   wr_data;
  logic          start;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done
  );
endinterface

// File: rtl/sk9822_chain_drv.sv
// SK9822/APA102 daisy-chain driver: per-LED frame buffer serialised as
// start frame, LED_NUM data frames and a chain-length-sized end frame.
module sk9822_chain_drv #(
  parameter int LED_NUM      = 12,
  parameter int CLK_DIV      = 25,
  parameter int AUTO_REFRESH = 0,
  parameter int AW           = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  sk9822_chain_drv_if.slave   host,
  output logic                sk9822_ck,
  output logic                sk9822_da
);

  localparam int END_BITS = 32 * ((LED_NUM + 63) / 64);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EOF_W    = $clog2(END_BITS);

  typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg;
  logic               ck_reg;
  logic [31:0]        shift_reg;
  logic [4:0]         bit_reg;
  logic [AW-1:0]      led_reg;
  logic [EOF_W-1:0]   eof_reg;
  logic               done_reg;
  logic [28:0]        fb [LED_NUM];

  logic               div_last, bit_end, word_end, led_last, eof_last, start_go;
  logic [AW-1:0]      led_inc;

  // Out-of-range addresses never match any entry, so they are dropped.
  for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_fb
    always_ff @(posedge clk) begin
      if (rst) begin
        fb[gi] <= '0;
      end else if (host.wr_en && host.wr_addr == AW'(gi)) begin
        fb[gi] <= host.wr_data;
      end
    end
  end

  assign div_last = (div_reg == DIV_W'(CLK_DIV - 1));
  assign bit_end  = ck_reg && div_last;
  assign word_end = (bit_reg == 5'd31);
  assign led_last = (led_reg == AW'(LED_NUM - 1));
  assign eof_last = (eof_reg == EOF_W'(END_BITS - 1));
  assign led_inc  = led_reg + AW'(1);
  assign start_go = host.start || ((AUTO_REFRESH != 0) && done_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_go) state_next = SOF;
      SOF:     if (bit_end && word_end) state_next = DATA;
      DATA:    if (bit_end && word_end && led_last) state_next = EOF;
      EOF:     if (bit_end && eof_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data advances only on the edge that ends a ck-high half, so da is stable
  // for a full half-period on either side of every rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg   <= '0;
      ck_reg    <= 1'b0;
      shift_reg <= '0;
      bit_reg   <= '0;
      led_reg   <= '0;
      eof_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        div_reg   <= '0;
        ck_reg    <= 1'b0;
        shift_reg <= '0;
        bit_reg   <= '0;
        led_reg   <= '0;
        eof_reg   <= '0;
      end else if (!div_last) begin
        div_reg <= div_reg + DIV_W'(1);
      end else begin
        div_reg <= '0;
        ck_reg  <= ~ck_reg;
        if (ck_reg) begin
          bit_reg   <= bit_reg + 5'd1;
          shift_reg <= {shift_reg[30:0], state_reg == EOF};
          case (state_reg)
            SOF: begin
              if (word_end) begin
                shift_reg <= {3'b111, fb[0]};
                led_reg   <= '0;
              end
            end
            DATA: begin
              if (word_end) begin
                if (led_last) begin
                  shift_reg <= '1;
                  eof_reg   <= '0;
                end else begin
                  led_reg   <= led_inc;
                  shift_reg <= {3'b111, fb[led_inc]};
                end
              end
            end
            EOF: begin
              if (eof_last) begin
                shift_reg <= '0;
                done_reg  <= 1'b1;
              end else begin
                eof_reg <= eof_reg + EOF_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    host.busy = (state_reg != IDLE);
    host.done = done_reg;
    sk9822_ck = ck_reg;
    sk9822_da = shift_reg[31];
  end

endmodule

// File: tb/tb_sk9822_chain_drv.sv
// Directed bench for sk9822_chain_drv: four instances cover the main 2-LED
// configuration, a 65-LED chain, a 1-LED/CLK_DIV=1 chain and auto-refresh.
module tb_sk9822_chain_drv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sk9822_chain_drv_if #(.AW(1)) bus0 ();
  sk9822_chain_drv_if #(.AW(7)) bus1 ();
  sk9822_chain_drv_if #(.AW(1)) bus2 ();
  sk9822_chain_drv_if #(.AW(1)) bus3 ();

  logic ck0, da0, ck1, da1, ck2, da2, ck3, da3;

  sk9822_chain_drv #(.LED_NUM(2), .CLK_DIV(2), .AUTO_REFRESH(0)) u0 (
    .clk(clk), .rst(rst), .host(bus0), .sk9822_ck(ck0), .sk9822_da(da0));
  sk9822_chain_drv #(.LED_NUM(65), .CLK_DIV(1), .AUTO_REFRESH(0)) u1 (
    .clk(clk), .rst(rst), .host(bus1), .sk9822_ck(ck1), .sk9822_da(da1));
  sk9822_chain_drv #(.LED_NUM(1), .CLK_DIV(1), .AUTO_REFRESH(0)) u2 (
    .clk(clk), .rst(rst), .host(bus2), .sk9822_ck(ck2), .sk9822_da(da2));
  sk9822_chain_drv #(.LED_NUM(2), .CLK_DIV(1), .AUTO_REFRESH(1)) u3 (
    .clk(clk), .rst(rst), .host(bus3), .sk9822_ck(ck3), .sk9822_da(da3));

  logic [3:0] ck_w, da_w, busy_w, done_w;
  assign ck_w   = {ck3, ck2, ck1, ck0};
  assign da_w   = {da3, da2, da1, da0};
  assign busy_w = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
  assign done_w = {bus3.done, bus2.done, bus1.done, bus0.done};

  // Strip-side monitor: captures da on every ck rise and tallies status.
  int   ncap [4];
  int   done_cnt [4];
  int   busy_cyc [4];
  int   viol [4];
  int   last_gap [4];
  int   idle_run [4];
  logic cap [4][0:2303];
  bit   ck_prev [4];
  bit   da_prev [4];
  bit   seen_busy [4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ck_w[i] && !ck_prev[i]) begin
        if (ncap[i] < 2304) cap[i][ncap[i]] = da_w[i];
        ncap[i]++;
      end
      if ((da_w[i] !== da_prev[i]) && ck_w[i]) viol[i]++;
      ck_prev[i] = ck_w[i];
      da_prev[i] = da_w[i];
      if (busy_w[i]) begin
        busy_cyc[i]++;
        if (seen_busy[i] && idle_run[i] > 0) last_gap[i] = idle_run[i];
        idle_run[i]  = 0;
        seen_busy[i] = 1'b1;
      end else if (rst) begin
        seen_busy[i] = 1'b0;
        idle_run[i]  = 0;
      end else begin
        idle_run[i]++;
      end
      if (done_w[i]) done_cnt[i]++;
    end
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [28:0] w0;
    logic [28:0] w1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [3];

  int snap_base, snap_done, snap_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i, input int base, input int k);
    logic [31:0] w = '0;
    for (int b = 0; b < 32; b++) begin
      int idx = base + 32 * k + b;
      w = {w[30:0], (idx < 2304) ? cap[i][idx] : 1'bx};
    end
    return w;
  endfunction

  task automatic wr(input int d, input int addr, input logic [28:0] data);
    case (d)
      0: begin bus0.wr_en = 1'b1; bus0.wr_addr = 1'(addr); bus0.wr_data = data; end
      1: begin bus1.wr_en = 1'b1; bus1.wr_addr = 7'(addr); bus1.wr_data = data; end
      2: begin bus2.wr_en = 1'b1; bus2.wr_addr = 1'(addr); bus2.wr_data = data; end
      default: begin bus3.wr_en = 1'b1; bus3.wr_addr = 1'(addr); bus3.wr_data = data; end
    endcase
    tick();
    bus0.wr_en = 1'b0;
    bus1.wr_en = 1'b0;
    bus2.wr_en = 1'b0;
    bus3.wr_en = 1'b0;
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: bus0.start = v;
      1: bus1.start = v;
      2: bus2.start = v;
      default: bus3.start = v;
    endcase
  endtask

  // Pulse start on one instance and check the first cycle of the refresh.
  task automatic begin_refresh(input int d, input string tag);
    snap_base = ncap[d];
    snap_done = done_cnt[d];
    snap_busy = busy_cyc[d];
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    check({tag, "_entry"}, {61'd0, busy_w[d], ck_w[d], da_w[d]}, 64'b100);
  endtask

  task automatic wait_done(input int d, input int limit, input string tag);
    int n = 0;
    while (!done_w[d] && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {63'd0, done_w[d]}, 64'd1);
    check({tag, "_end_pins"}, {61'd0, busy_w[d], ck_w[d], da_w[d]}, 64'd0);
    tick();
    tick();
    check({tag, "_done_once"}, 64'(done_cnt[d] - snap_done), 64'd1);
    check({tag, "_idle_after"}, {63'd0, busy_w[d]}, 64'd0);
  endtask

  task automatic finish0(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    wait_done(0, 700, tag);
    check({tag, "_bits"}, 64'(ncap[0] - snap_base), 64'd128);
    check({tag, "_busy_len"}, 64'(busy_cyc[0] - snap_busy), 64'd512);
    check({tag, "_sof"}, {32'd0, word_at(0, snap_base, 0)}, 64'h0);
    check({tag, "_led0"}, {32'd0, word_at(0, snap_base, 1)}, {32'd0, e0});
    check({tag, "_led1"}, {32'd0, word_at(0, snap_base, 2)}, {32'd0, e1});
    check({tag, "_eof"}, {32'd0, word_at(0, snap_base, 3)}, 64'hFFFF_FFFF);
  endtask

  initial begin
    tbl[0] = '{1'b0, 29'h0,        29'h0,        32'hE000_0000, 32'hE000_0000};
    tbl[1] = '{1'b1, 29'h1F0000FF, 29'h0F123456, 32'hFF00_00FF, 32'hEF12_3456};
    tbl[2] = '{1'b1, 29'h15A5A5A5, 29'h00000001, 32'hF5A5_A5A5, 32'hE000_0001};

    // Reset with random input activity.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus0.wr_en = 1'($urandom); bus0.wr_addr = 1'($urandom); bus0.wr_data = 29'($urandom); bus0.start = 1'($urandom);
      bus1.wr_en = 1'($urandom); bus1.wr_addr = 7'($urandom); bus1.wr_data = 29'($urandom); bus1.start = 1'($urandom);
      bus2.wr_en = 1'($urandom); bus2.wr_addr = 1'($urandom); bus2.wr_data = 29'($urandom); bus2.start = 1'($urandom);
      bus3.wr_en = 1'($urandom); bus3.wr_addr = 1'($urandom); bus3.wr_data = 29'($urandom); bus3.start = 1'($urandom);
      tick();
    end
    check("reset_outputs", {48'd0, busy_w, done_w, ck_w, da_w}, 64'd0);
    bus0.wr_en = 0; bus0.start = 0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus1.wr_en = 0; bus1.start = 0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus2.wr_en = 0; bus2.start = 0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus3.wr_en = 0; bus3.start = 0; bus3.wr_addr = '0; bus3.wr_data = '0;
    rst = 1'b0;
    tick();
    check("post_reset_idle", {48'd0, busy_w, done_w, ck_w, da_w}, 64'd0);

    // Table-driven refreshes on the 2-LED instance; entry 0 reads the cleared buffer.
    for (int v = 0; v < 3; v++) begin
      if (tbl[v].wr) begin
        wr(0, 0, tbl[v].w0);
        wr(0, 1, tbl[v].w1);
      end
      begin_refresh(0, $sformatf("vec%0d", v));
      finish0($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1);
      $display("vec%0d led0=%08h led1=%08h", v, word_at(0, snap_base, 1), word_at(0, snap_base, 2));
    end

    // Writes during a refresh: LED1 during SOF is sent, LED0 during LED1 waits.
    wr(0, 0, 29'h1F0000FF);
    wr(0, 1, 29'h0F123456);
    begin_refresh(0, "wbusy");
    repeat (10) tick();
    wr(0, 1, 29'h01ABCDEF);
    repeat (289) tick();
    wr(0, 0, 29'h1F000000);
    finish0("wbusy", 32'hFF00_00FF, 32'hE1AB_CDEF);
    $display("wbusy led0=%08h led1=%08h", word_at(0, snap_base, 1), word_at(0, snap_base, 2));
    begin_refresh(0, "wnext");
    finish0("wnext", 32'hFF00_0000, 32'hE1AB_CDEF);
    $display("wnext led0=%08h", word_at(0, snap_base, 1));

    // start pulses every 7 cycles while busy produce no extra refresh.
    begin_refresh(0, "ignstart");
    for (int n = 1; n <= 480; n++) begin
      set_start(0, (n % 7) == 0);
      tick();
    end
    set_start(0, 1'b0);
    finish0("ignstart", 32'hFF00_0000, 32'hE1AB_CDEF);
    repeat (20) tick();
    check("ignstart_no_rerun", 64'(done_cnt[0] - snap_done), 64'd1);
    $display("ignstart done_pulses=%0d", done_cnt[0] - snap_done);

    // 65-LED chain: 64-bit end frame, out-of-range addresses dropped.
    wr(1, 64, 29'h0F123456);
    wr(1, 65, 29'h1FFFFFFF);
    wr(1, 127, 29'h1FFFFFFF);
    begin_refresh(1, "led65");
    wait_done(1, 5000, "led65");
    check("led65_bits", 64'(ncap[1] - snap_base), 64'd2176);
    check("led65_busy_len", 64'(busy_cyc[1] - snap_busy), 64'd4352);
    check("led65_led0", {32'd0, word_at(1, snap_base, 1)}, 64'hE000_0000);
    check("led65_led63", {32'd0, word_at(1, snap_base, 64)}, 64'hE000_0000);
    check("led65_led64", {32'd0, word_at(1, snap_base, 65)}, 64'hEF12_3456);
    check("led65_eof_a", {32'd0, word_at(1, snap_base, 66)}, 64'hFFFF_FFFF);
    check("led65_eof_b", {32'd0, word_at(1, snap_base, 67)}, 64'hFFFF_FFFF);
    $display("led65 bits=%0d led64=%08h", ncap[1] - snap_base, word_at(1, snap_base, 65));

    // Single LED with one-cycle half-periods.
    wr(2, 0, 29'h0ABCDEF1);
    begin_refresh(2, "led1");
    wait_done(2, 400, "led1");
    check("led1_bits", 64'(ncap[2] - snap_base), 64'd96);
    check("led1_busy_len", 64'(busy_cyc[2] - snap_busy), 64'd192);
    check("led1_sof", {32'd0, word_at(2, snap_base, 0)}, 64'h0);
    check("led1_led0", {32'd0, word_at(2, snap_base, 1)}, 64'hEABC_DEF1);
    check("led1_eof", {32'd0, word_at(2, snap_base, 2)}, 64'hFFFF_FFFF);
    $display("led1 led0=%08h", word_at(2, snap_base, 1));

    // Reset in the middle of LED0's data (bit 10 of the word).
    wr(0, 0, 29'h1F0000FF);
    wr(0, 1, 29'h0F123456);
    begin_refresh(0, "midrst");
    repeat (169) tick();
    check("midrst_in_data", {63'd0, busy_w[0]}, 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_outputs", {60'd0, busy_w[0], done_w[0], ck_w[0], da_w[0]}, 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", 64'(done_cnt[0] - snap_done), 64'd0);
    wr(0, 0, 29'h1F0000FF);
    begin_refresh(0, "afterrst");
    finish0("afterrst", 32'hFF00_00FF, 32'hE000_0000);
    $display("afterrst led0=%08h led1=%08h", word_at(0, snap_base, 1), word_at(0, snap_base, 2));

    // Auto-refresh: one start, then back-to-back refreshes with a 1-cycle gap.
    begin_refresh(3, "auto");
    repeat (700) tick();
    check("auto_multi", {63'd0, (done_cnt[3] - snap_done) >= 2}, 64'd1);
    check("auto_gap", 64'(last_gap[3]), 64'd1);
    $display("auto refreshes=%0d gap=%0d", done_cnt[3] - snap_done, last_gap[3]);

    check("da_stable_u0", 64'(viol[0]), 64'd0);
    check("da_stable_u1", 64'(viol[1]), 64'd0);
    check("da_stable_u2", 64'(viol[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
